router_fifo_buf: RTL and testbench

- Per-destination output FIFO of the 1x3 router. One instance per port, three in total.
- Sits directly downstream of the register/datapath stage. It stores the byte stream that stage drives on dout (header, then payload, then parity) and presents it to the destination read side.
- Each entry carries a header tag, so the read side tracks packet length and flags the last byte of each packet.
- The sync block drives soft_rst to discard a stranded packet.

---
 rtl/router_pkg.sv | 11 +
 rtl/router_fifo_mem.sv | 26 ++
 rtl/router_fifo_buf.sv | 106 ++++++++++
 tb/tb_router_fifo_buf.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: byte width and header field positions.
// No logic; used by the sync block, register stage and output FIFOs.
// Header byte layout: [7:2] payload length, [1:0] destination address.
package router_pkg;
  localparam int WIDTH        = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int MAX_PAYLOAD  = 63;
endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one async read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller guarantees writes only go to free entries.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 9,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write; contents need no reset since no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo_buf.sv
// Per-destination output FIFO tagging header bytes and flagging the last byte of each packet.
// Latency: written byte poppable next cycle; popped byte on dout one cycle after read_enb.
// Backpressure: writes while full are dropped; reads while empty return dout_valid = 0.
module router_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             full,
  output logic             empty
);
  import router_pkg::*;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             lfd_q;
  logic [6:0]       pkt_cnt;
  logic             do_wr;
  logic             do_rd;
  logic [WIDTH:0]   rd_entry;
  logic             rd_hdr;
  logic [WIDTH-1:0] rd_byte;
  logic [6:0]       hdr_cnt;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Flags use pre-edge pointers, so a write at full is dropped even with a concurrent read.
  assign do_wr = write_enb && !full && !soft_rst;
  assign do_rd = read_enb && !empty && !soft_rst;

  assign rd_hdr  = rd_entry[WIDTH];
  assign rd_byte = rd_entry[WIDTH-1:0];
  // Count payload bytes plus the trailing parity byte.
  assign hdr_cnt = 7'(rd_byte[HDR_LEN_MSB:HDR_LEN_LSB]) + 7'd1;

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({lfd_q, din}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Write side: header tag delay (register stage emits header one cycle after lfd_state) and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      lfd_q  <= 1'b0;
    end else if (soft_rst) begin
      wr_ptr <= '0;
      lfd_q  <= 1'b0;
    end else begin
      lfd_q <= lfd_state;
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
    end
  end

  // Read side: pop into the output register and track remaining bytes of the current packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (soft_rst) begin
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (do_rd) begin
      rd_ptr     <= rd_ptr + (AW+1)'(1);
      dout       <= rd_byte;
      dout_valid <= 1'b1;
      dout_last  <= !rd_hdr && (pkt_cnt == 7'd1);
      if (rd_hdr) begin
        pkt_cnt <= hdr_cnt;
      end else if (pkt_cnt != 7'd0) begin
        pkt_cnt <= pkt_cnt - 7'd1;
      end
    end else begin
      // dout keeps its last value; the qualifiers drop.
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_fifo_buf.sv
module tb_router_fifo_buf;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_last;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  router_fifo_buf #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_rst   (soft_rst),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    write_enb = 1'b1;
    din = b;
    tick();
    write_enb = 1'b0;
  endtask

  task automatic lfd_pulse();
    lfd_state = 1'b1;
    tick();
    lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; soft_rst = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; din = 8'h00;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: empty=%b full=%b dout=%h valid=%b last=%b, need 1 0 00 0 0",
               empty, full, dout, dout_valid, dout_last);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    logic [7:0] exp [5];
    exp[0] = 8'h0D; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3; exp[4] = 8'h0C;
    lfd_pulse();
    for (int i = 0; i < 5; i++) wr_byte(exp[i]);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dout !== exp[i] || dout_valid !== 1'b1 || dout_last !== (i == 4)) begin
        errors++;
        $display("FAIL passthrough[%0d]: dout=%h valid=%b last=%b, need %h 1 %b",
                 i, dout, dout_valid, dout_last, exp[i], (i == 4));
      end
    end
    read_enb = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL passthrough_end: valid=%b empty=%b, need 0 1", dout_valid, empty);
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 17; i++) begin
      wr_byte(8'(i));
      if (i == 15 || i == 16) begin
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
          errors++;
          $display("FAIL full_after_%0d: full=%b empty=%b, need 1 0", i + 1, full, empty);
        end
      end
    end
    read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (dout !== 8'(i) || dout_valid !== 1'b1 || dout_last !== 1'b0) begin
        errors++;
        $display("FAIL full_read[%0d]: dout=%h valid=%b last=%b, need %h 1 0",
                 i, dout, dout_valid, dout_last, 8'(i));
      end
    end
    read_enb = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: empty=%b full=%b, need 1 0", empty, full);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) wr_byte(8'(r * 16 + i + 8'h30));
      read_enb = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        checks++;
        if (dout !== 8'(r * 16 + i + 8'h30) || dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap_r%0d[%0d]: dout=%h valid=%b, need %h 1",
                   r, i, dout, dout_valid, 8'(r * 16 + i + 8'h30));
        end
      end
      read_enb = 1'b0;
    end
    // Hold occupancy at 8 with simultaneous read and write.
    for (int i = 0; i < 8; i++) wr_byte(8'h80 + 8'(i));
    read_enb = 1'b1;
    write_enb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'h90 + 8'(i);
      tick();
      checks++;
      if (dout !== (i < 8 ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 8)) || full !== 1'b0 || empty !== 1'b0) begin
        errors++;
        $display("FAIL steady[%0d]: dout=%h full=%b empty=%b, need %h 0 0",
                 i, dout, full, empty, (i < 8 ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 8)));
      end
    end
    write_enb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dout !== 8'h90 + 8'(12 + i) || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL steady_drain[%0d]: dout=%h valid=%b, need %h 1",
                 i, dout, dout_valid, 8'h90 + 8'(12 + i));
      end
    end
    read_enb = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL steady_occupancy: empty=%b after 8 drains, need 1", empty);
    end
  endtask

  task automatic test_soft_flush();
    logic [7:0] exp [3];
    lfd_pulse();
    wr_byte(8'h50);
    for (int i = 0; i < 15; i++) wr_byte(8'hC0 + 8'(i));
    read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout !== (i == 0 ? 8'h50 : 8'hC0 + 8'(i - 1)) || dout_last !== 1'b0) begin
        errors++;
        $display("FAIL flush_pre[%0d]: dout=%h last=%b, need %h 0",
                 i, dout, dout_last, (i == 0 ? 8'h50 : 8'hC0 + 8'(i - 1)));
      end
    end
    // Concurrent read and write during the flush must be ignored.
    soft_rst = 1'b1;
    write_enb = 1'b1;
    din = 8'hEE;
    tick();
    soft_rst = 1'b0;
    write_enb = 1'b0;
    read_enb = 1'b0;
    checks++;
    if (empty !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'h00 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: empty=%b valid=%b dout=%h last=%b, need 1 0 00 0",
               empty, dout_valid, dout, dout_last);
    end
    exp[0] = 8'h04; exp[1] = 8'h11; exp[2] = 8'h15;
    lfd_pulse();
    for (int i = 0; i < 3; i++) wr_byte(exp[i]);
    read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout !== exp[i] || dout_valid !== 1'b1 || dout_last !== (i == 2)) begin
        errors++;
        $display("FAIL flush_post[%0d]: dout=%h valid=%b last=%b, need %h 1 %b",
                 i, dout, dout_valid, dout_last, exp[i], (i == 2));
      end
    end
    read_enb = 1'b0;
  endtask

  task automatic test_edges();
    int pops;
    // Read while empty: dout must keep 0x15 from the previous packet.
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h15) begin
      errors++;
      $display("FAIL read_empty: valid=%b dout=%h, need 0 15", dout_valid, dout);
    end
    for (int i = 0; i < 16; i++) wr_byte(8'h20 + 8'(i));
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL edge_fill: full=%b, need 1", full);
    end
    write_enb = 1'b1;
    read_enb = 1'b1;
    din = 8'hEE;
    tick();
    write_enb = 1'b0;
    checks++;
    if (dout !== 8'h20 || dout_valid !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: dout=%h valid=%b full=%b, need 20 1 0", dout, dout_valid, full);
    end
    pops = 0;
    for (int i = 0; i < 20 && !empty; i++) begin
      tick();
      pops++;
      checks++;
      if (dout !== 8'h21 + 8'(i)) begin
        errors++;
        $display("FAIL full_rw_drain[%0d]: dout=%h, need %h", i, dout, 8'h21 + 8'(i));
      end
    end
    read_enb = 1'b0;
    checks++;
    if (pops != 15) begin
      errors++;
      $display("FAIL full_rw_occupancy: remaining=%0d, need 15", pops);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 5; i++) wr_byte(8'h60 + 8'(i));
    #2 rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: empty=%b full=%b dout=%h valid=%b last=%b, need 1 0 00 0 0",
               empty, full, dout, dout_valid, dout_last);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_full_boundary();
    test_wrap();
    test_soft_flush();
    test_edges();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
